// File: rtl/iopad_ns_driver.sv
// ----------------------------------------------------------------------------
// iopad_ns_driver
//
// Drives a group of bidirectional pads from a core-side valid/ready stream.
// A turnaround FSM (IDLE -> LEAD -> DRIVE -> TRAIL -> IDLE) keeps the pad
// drivers off for TURN_CYCLES guard cycles before enabling them and after
// releasing them, so two drivers never contend on the shared pad net.
// The tristate buffers themselves live in the top level.
//
// Parameters:
//   WIDTH        number of pads in the group
//   TURN_CYCLES  guard cycles before drive and after release (>= 1)
//   HOLD_CYCLES  cycles each accepted word is driven (>= 1)
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   tx_valid      core word valid
//   tx_ready      block accepts a word this cycle (state/counter decode only)
//   tx_data       word to drive
//   tx_last       last word of burst; pads are released after it
//   iopad_out     pad output data (registered)
//   iopad_oe      pad output enable, active-high (registered)
//   iopad_in      pad readback value from the input buffer
//   err_clr       clears readback_err
//   readback_err  sticky readback mismatch flag
//   busy          high whenever the FSM is not in IDLE
//
// Build option:
//   IOPAD_READBACK_EN  when defined, the pad value is compared against the
//                      driven word on the last DRIVE cycle of each word and a
//                      mismatch sets readback_err. When undefined,
//                      readback_err is tied low and iopad_in/err_clr are
//                      ignored.
// ----------------------------------------------------------------------------
module iopad_ns_driver #(
    parameter int WIDTH       = 3,
    parameter int TURN_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_last,
    output logic [WIDTH-1:0] iopad_out,
    output logic             iopad_oe,
    input  logic [WIDTH-1:0] iopad_in,
    input  logic             err_clr,
    output logic             readback_err,
    output logic             busy
);

    localparam int CNT_MAX = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_DRIVE = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_last;
    logic             r_oe;

    logic             w_cnt_zero;
    logic             w_ready;
    logic             w_load;
    logic             w_xfer;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_xfer     = tx_valid & w_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer)     w_next = S_LEAD;
            S_LEAD:  if (w_cnt_zero) w_next = S_DRIVE;
            // A word accepted on the final hold cycle keeps us in DRIVE so
            // the enable never drops between back-to-back words.
            S_DRIVE: if (w_cnt_zero) w_next = w_xfer ? S_DRIVE : S_TRAIL;
            S_TRAIL: if (w_cnt_zero) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath-control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready   = 1'b0;
        w_load    = 1'b0;
        // Free-running countdown that saturates at zero.
        w_cnt_nxt = w_cnt_zero ? '0 : (r_cnt - CW'(1));
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (tx_valid) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = TURN_LD;
                end
            end
            S_LEAD: begin
                if (w_cnt_zero) w_cnt_nxt = HOLD_LD;
            end
            S_DRIVE: begin
                // Ready only on the last hold cycle of a non-final word;
                // decoded from state/counter/latched last, never tx_valid.
                w_ready = w_cnt_zero & ~r_last;
                if (w_cnt_zero) begin
                    if (tx_valid && w_ready) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = HOLD_LD;
                    end else begin
                        w_cnt_nxt = TURN_LD;
                    end
                end
            end
            S_TRAIL: begin
                w_ready = 1'b0;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, latched word, registered pad controls
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
            r_oe   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_load) begin
                r_data <= tx_data;
                r_last <= tx_last;
            end
            // Enable is registered from the next state so it rises on the
            // edge that enters DRIVE and falls on the edge that leaves it.
            r_oe <= (w_next == S_DRIVE);
        end
    end

    assign tx_ready  = w_ready;
    assign busy      = (r_state != S_IDLE);
    assign iopad_out = r_data;
    assign iopad_oe  = r_oe;

    // ------------------------------------------------------------------
    // Optional pad readback check
    // ------------------------------------------------------------------
`ifdef IOPAD_READBACK_EN
    logic w_rb_fail;
    logic r_rb_err;

    // Sample on the last hold cycle, when the pad has settled longest.
    assign w_rb_fail = (r_state == S_DRIVE) & w_cnt_zero & (iopad_in != r_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb_err <= 1'b0;
        end else if (w_rb_fail) begin
            r_rb_err <= 1'b1;   // a new mismatch beats a same-cycle clear
        end else if (err_clr) begin
            r_rb_err <= 1'b0;
        end
    end

    assign readback_err = r_rb_err;
`else
    logic w_unused_rb;
    assign w_unused_rb  = ^{iopad_in, err_clr};
    assign readback_err = 1'b0;
`endif

endmodule

// File: tb/tb_iopad_ns_driver.sv
module tb_iopad_ns_driver;

`ifdef IOPAD_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: T=2, H=1
    logic       a_rst, a_valid, a_rdy, a_last, a_oe, a_clr, a_err, a_busy;
    logic [2:0] a_data, a_out, a_in;
    // Instance B: T=2, H=2 (burst / reset-in-drive)
    logic       b_rst, b_valid, b_rdy, b_last, b_oe, b_clr, b_err, b_busy;
    logic [2:0] b_data, b_out;

    iopad_ns_driver #(.WIDTH(3), .TURN_CYCLES(2), .HOLD_CYCLES(1)) u_a (
        .clk(clk), .rst(a_rst), .tx_valid(a_valid), .tx_ready(a_rdy),
        .tx_data(a_data), .tx_last(a_last), .iopad_out(a_out), .iopad_oe(a_oe),
        .iopad_in(a_in), .err_clr(a_clr), .readback_err(a_err), .busy(a_busy)
    );

    // B reads back exactly what it drives, so it must never flag an error.
    iopad_ns_driver #(.WIDTH(3), .TURN_CYCLES(2), .HOLD_CYCLES(2)) u_b (
        .clk(clk), .rst(b_rst), .tx_valid(b_valid), .tx_ready(b_rdy),
        .tx_data(b_data), .tx_last(b_last), .iopad_out(b_out), .iopad_oe(b_oe),
        .iopad_in(b_out), .err_clr(b_clr), .readback_err(b_err), .busy(b_busy)
    );

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (a_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_a_oe got %b exp 0", a_oe); end
        if (a_out !== 3'b000) begin n_fail++; $display("FAIL reset_a_out got %b exp 000", a_out); end
        if (a_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_a_rdy got %b exp 1", a_rdy); end
        if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL reset_a_busy got %b exp 0", a_busy); end
        if (a_err !== 1'b0)   begin n_fail++; $display("FAIL reset_a_err got %b exp 0", a_err); end
        n_checks += 3;
        if (b_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_b_oe got %b exp 0", b_oe); end
        if (b_out !== 3'b000) begin n_fail++; $display("FAIL reset_b_out got %b exp 000", b_out); end
        if (b_rdy !== 1'b1)   begin n_fail++; $display("FAIL reset_b_rdy got %b exp 1", b_rdy); end
        a_rst = 1'b0;
        b_rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks += 4;
            if (a_oe !== 1'b0)    begin n_fail++; $display("FAIL idle_oe k=%0d got %b exp 0", k, a_oe); end
            if (a_out !== 3'b000) begin n_fail++; $display("FAIL idle_out k=%0d got %b exp 000", k, a_out); end
            if (a_rdy !== 1'b1)   begin n_fail++; $display("FAIL idle_rdy k=%0d got %b exp 1", k, a_rdy); end
            if (a_busy !== 1'b0)  begin n_fail++; $display("FAIL idle_busy k=%0d got %b exp 0", k, a_busy); end
        end
    endtask

    // One last-flagged word on A (T=2,H=1). Cycle k is the period after the
    // k-th edge following acceptance: LEAD k=1,2; DRIVE k=3; TRAIL k=4,5;
    // IDLE k=6. Readback compare happens in k=3, flag visible from k=4.
    task automatic test_single_word(input string nm, input logic [2:0] d,
                                    input logic [2:0] pin, input bit clr);
        bit   mism;
        logic e_oe, e_rdy, e_busy, e_err;
        mism = (pin != d);
        @(negedge clk);
        a_valid = 1'b1; a_data = d; a_last = 1'b1; a_in = pin; a_clr = clr;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            e_oe   = (k == 3);
            e_rdy  = (k == 6);
            e_busy = (k != 6);
            e_err  = RB_EN && mism && (k >= 4) && (k == 4 || !clr);
            n_checks += 5;
            if (a_oe !== e_oe)     begin n_fail++; $display("FAIL %s_oe k=%0d got %b exp %b", nm, k, a_oe, e_oe); end
            if (a_rdy !== e_rdy)   begin n_fail++; $display("FAIL %s_rdy k=%0d got %b exp %b", nm, k, a_rdy, e_rdy); end
            if (a_busy !== e_busy) begin n_fail++; $display("FAIL %s_busy k=%0d got %b exp %b", nm, k, a_busy, e_busy); end
            if (a_out !== d)       begin n_fail++; $display("FAIL %s_out k=%0d got %b exp %b", nm, k, a_out, d); end
            if (a_err !== e_err)   begin n_fail++; $display("FAIL %s_err k=%0d got %b exp %b", nm, k, a_err, e_err); end
            if (k < 6) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        a_clr = 1'b0;
    endtask

    task automatic test_err_sticky();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (a_err !== RB_EN) begin n_fail++; $display("FAIL err_sticky k=%0d got %b exp %b", k, a_err, RB_EN); end
        end
    endtask

    task automatic test_err_clr();
        @(negedge clk);
        a_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_clr = 1'b0;
        n_checks++;
        if (a_err !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b exp 0", a_err); end
    endtask

    // Three-word burst on B (T=2,H=2). Optional reset asserted during cycle
    // rst_at so it takes effect on the edge that ends that cycle.
    task automatic test_burst(input string nm, input int rst_at);
        logic [2:0]  wd [3];
        logic [11:0] e_oe, e_rdy, e_busy;
        logic [2:0]  e_out;
        int          w;
        bit          will;
        wd[0] = 3'b001; wd[1] = 3'b010; wd[2] = 3'b100;
        e_oe   = 12'h1F8;   // k=3..8
        e_rdy  = 12'h850;   // k=4,6,11
        e_busy = 12'h7FE;   // k=1..10
        w = 0;
        @(negedge clk);
        b_valid = 1'b1; b_data = wd[0]; b_last = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0 && rst_at > 0 && k == rst_at + 1) begin
                n_checks += 4;
                if (b_oe !== 1'b0)    begin n_fail++; $display("FAIL %s_oe got %b exp 0", nm, b_oe); end
                if (b_out !== 3'b000) begin n_fail++; $display("FAIL %s_out got %b exp 000", nm, b_out); end
                if (b_busy !== 1'b0)  begin n_fail++; $display("FAIL %s_busy got %b exp 0", nm, b_busy); end
                if (b_rdy !== 1'b1)   begin n_fail++; $display("FAIL %s_rdy got %b exp 1", nm, b_rdy); end
                b_rst   = 1'b0;
                b_valid = 1'b0;
                break;
            end
            if (k > 0) begin
                e_out = (k <= 4) ? 3'b001 : (k <= 6) ? 3'b010 : 3'b100;
                n_checks += 4;
                if (b_oe !== e_oe[k])     begin n_fail++; $display("FAIL %s_oe k=%0d got %b exp %b", nm, k, b_oe, e_oe[k]); end
                if (b_rdy !== e_rdy[k])   begin n_fail++; $display("FAIL %s_rdy k=%0d got %b exp %b", nm, k, b_rdy, e_rdy[k]); end
                if (b_busy !== e_busy[k]) begin n_fail++; $display("FAIL %s_busy k=%0d got %b exp %b", nm, k, b_busy, e_busy[k]); end
                if (b_out !== e_out)      begin n_fail++; $display("FAIL %s_out k=%0d got %b exp %b", nm, k, b_out, e_out); end
            end
            will = b_valid & b_rdy;
            if (rst_at > 0 && k == rst_at) b_rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (will) begin
                w++;
                if (w < 3) begin
                    b_data = wd[w];
                    b_last = (w == 2);
                end else begin
                    b_valid = 1'b0;
                end
            end
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    // Single word on B after a reset: LEAD k=1,2; DRIVE k=3,4; TRAIL 5,6; IDLE 7.
    task automatic test_after_reset();
        logic e_oe, e_rdy;
        @(negedge clk);
        b_valid = 1'b1; b_data = 3'b110; b_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            e_oe  = (k == 3) || (k == 4);
            e_rdy = (k == 7);
            n_checks += 3;
            if (b_oe !== e_oe)    begin n_fail++; $display("FAIL post_rst_oe k=%0d got %b exp %b", k, b_oe, e_oe); end
            if (b_rdy !== e_rdy)  begin n_fail++; $display("FAIL post_rst_rdy k=%0d got %b exp %b", k, b_rdy, e_rdy); end
            if (b_out !== 3'b110) begin n_fail++; $display("FAIL post_rst_out k=%0d got %b exp 110", k, b_out); end
            if (k < 7) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        n_checks++;
        if (b_err !== 1'b0) begin n_fail++; $display("FAIL b_err got %b exp 0", b_err); end
    endtask

    initial begin
        a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_in = '0; a_clr = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_clr = 1'b0;

        test_reset();
        test_idle();
        test_single_word("single", 3'b101, 3'b000, 1'b0);
        test_err_sticky();
        test_err_clr();
        test_single_word("rb_match", 3'b011, 3'b011, 1'b0);
        test_single_word("rb_set_wins", 3'b101, 3'b000, 1'b1);
        test_burst("burst", 0);
        test_burst("rst_drive", 4);
        test_after_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
